// File: rtl/id_dual_issue_ctrl_pkg.sv
// Shared definitions for the dual-pipe ID->EX issue scheduler:
// FSM state encoding, default register-address width and the zero-register id.
package id_dual_issue_ctrl_pkg;

    typedef enum logic {
        ST_PAIR  = 1'b0,
        ST_SPLIT = 1'b1
    } issue_state_e;

    localparam int REG_AW_DEF = 5;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/id_loaduse_chk.sv
// Load-use hazard check of one ID instruction against both EX slots.
// Purely combinational; a load targeting x0 never creates a dependency.
module id_loaduse_chk
    import id_dual_issue_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_ex1_valid,
    input  logic              i_ex1_load,
    input  logic [REG_AW-1:0] i_ex1_rd,
    input  logic              i_ex2_valid,
    input  logic              i_ex2_load,
    input  logic [REG_AW-1:0] i_ex2_rd,
    output logic              o_hazard
);

    logic [REG_AW-1:0] w_zero;
    logic              w_hit1;
    logic              w_hit2;

    assign w_zero = REG_AW'(ZERO_REG);

    assign w_hit1 = i_ex1_valid & i_ex1_load & (i_ex1_rd != w_zero) &
                    ((i_rs1 == i_ex1_rd) | (i_rs2 == i_ex1_rd));
    assign w_hit2 = i_ex2_valid & i_ex2_load & (i_ex2_rd != w_zero) &
                    ((i_rs1 == i_ex2_rd) | (i_rs2 == i_ex2_rd));

    assign o_hazard = i_id_valid & (w_hit1 | w_hit2);

endmodule

// File: rtl/id_dual_issue_ctrl.sv
// Dual-pipe ID->EX issue scheduler with in-order split issue (PAIR/SPLIT FSM).
// Optional performance counters are enabled with macro ID_ISSUE_PERF_EN.
module id_dual_issue_ctrl
    import id_dual_issue_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int PERF_CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id1_valid,
    input  logic              id2_valid,
    input  logic              id_order,
    input  logic [REG_AW-1:0] id1_rs1,
    input  logic [REG_AW-1:0] id1_rs2,
    input  logic [REG_AW-1:0] id1_rd,
    input  logic              id1_regwrite,
    input  logic              id1_memop,
    input  logic              id1_branch,
    input  logic [REG_AW-1:0] id2_rs1,
    input  logic [REG_AW-1:0] id2_rs2,
    input  logic [REG_AW-1:0] id2_rd,
    input  logic              id2_regwrite,
    input  logic              id2_memop,
    input  logic              id2_branch,
    input  logic              ex1_valid,
    input  logic              ex1_load,
    input  logic [REG_AW-1:0] ex1_rd,
    input  logic              ex2_valid,
    input  logic              ex2_load,
    input  logic [REG_AW-1:0] ex2_rd,
    input  logic              ex_flush,
    output logic              id1_act,
    output logic              id2_act,
    output logic              ex1_issue,
    output logic              ex2_issue,
    output logic              id_hold,
    output logic              split_q
`ifdef ID_ISSUE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_split_cnt
`endif
);

    issue_state_e      r_state;
    issue_state_e      w_nxt;
    logic [REG_AW-1:0] w_zero;
    logic              w_old2, w_both, w_any;
    logic              w_lu1, w_lu2, w_o_lu, w_y_lu;
    logic [REG_AW-1:0] w_o_rd, w_y_rd, w_y_rs1, w_y_rs2;
    logic              w_o_rw, w_y_rw, w_pair_hz;
    logic              w_iss_old, w_iss_yng, w_hold;

    assign w_zero = REG_AW'(ZERO_REG);

    // A lone valid instruction is always the older one, whatever id_order says.
    assign w_old2 = id2_valid & (~id1_valid | id_order);
    assign w_both = id1_valid & id2_valid;
    assign w_any  = id1_valid | id2_valid;

    id_loaduse_chk #(.REG_AW(REG_AW)) u_lu1 (
        .i_id_valid (id1_valid), .i_rs1(id1_rs1), .i_rs2(id1_rs2),
        .i_ex1_valid(ex1_valid), .i_ex1_load(ex1_load), .i_ex1_rd(ex1_rd),
        .i_ex2_valid(ex2_valid), .i_ex2_load(ex2_load), .i_ex2_rd(ex2_rd),
        .o_hazard   (w_lu1)
    );

    id_loaduse_chk #(.REG_AW(REG_AW)) u_lu2 (
        .i_id_valid (id2_valid), .i_rs1(id2_rs1), .i_rs2(id2_rs2),
        .i_ex1_valid(ex1_valid), .i_ex1_load(ex1_load), .i_ex1_rd(ex1_rd),
        .i_ex2_valid(ex2_valid), .i_ex2_load(ex2_load), .i_ex2_rd(ex2_rd),
        .o_hazard   (w_lu2)
    );

    assign w_o_lu  = w_old2 ? w_lu2        : w_lu1;
    assign w_y_lu  = w_old2 ? w_lu1        : w_lu2;
    assign w_o_rd  = w_old2 ? id2_rd       : id1_rd;
    assign w_o_rw  = w_old2 ? id2_regwrite : id1_regwrite;
    assign w_y_rd  = w_old2 ? id1_rd       : id2_rd;
    assign w_y_rw  = w_old2 ? id1_regwrite : id2_regwrite;
    assign w_y_rs1 = w_old2 ? id1_rs1      : id2_rs1;
    assign w_y_rs2 = w_old2 ? id1_rs2      : id2_rs2;

    assign w_pair_hz = (w_o_rw & (w_o_rd != w_zero) &
                        ((w_y_rs1 == w_o_rd) | (w_y_rs2 == w_o_rd))) |
                       (w_o_rw & w_y_rw & (w_o_rd == w_y_rd) & (w_o_rd != w_zero)) |
                       (id1_memop & id2_memop) |
                       (id1_branch & id2_branch);

    always_comb begin
        w_iss_old = 1'b0;
        w_iss_yng = 1'b0;
        w_hold    = 1'b0;
        w_nxt     = r_state;
        if (ex_flush) begin
            w_nxt = ST_PAIR;
        end else if (r_state == ST_PAIR) begin
            if (!w_any || w_o_lu) begin
                w_hold = w_any;
            end else begin
                w_iss_old = 1'b1;
                if (w_both) begin
                    if (!w_pair_hz && !w_y_lu) begin
                        w_iss_yng = 1'b1;
                    end else begin
                        w_hold = 1'b1;
                        w_nxt  = ST_SPLIT;
                    end
                end
            end
        end else begin
            // Older half already went down; only the younger remains in ID.
            if (w_both && w_y_lu) begin
                w_hold = 1'b1;
            end else begin
                w_iss_yng = w_both;
                w_nxt     = ST_PAIR;
            end
        end
    end

    assign id1_act   = ~RST;
    assign id2_act   = ~RST;
    assign ex1_issue = ~RST & ((w_iss_old & ~w_old2) | (w_iss_yng & w_old2));
    assign ex2_issue = ~RST & ((w_iss_old & w_old2) | (w_iss_yng & ~w_old2));
    assign id_hold   = ~RST & w_hold;
    assign split_q   = ~RST & (r_state == ST_SPLIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_PAIR;
        end else begin
            r_state <= w_nxt;
        end
    end

`ifdef ID_ISSUE_PERF_EN
    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic [PERF_CNT_W-1:0] r_split_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_split_cnt <= '0;
        end else begin
            if (w_hold && !ex_flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((r_state == ST_PAIR) && (w_nxt == ST_SPLIT) && (r_split_cnt != '1)) begin
                r_split_cnt <= r_split_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_split_cnt = r_split_cnt;
`else
    logic [PERF_CNT_W-1:0] w_unused_perf;
    assign w_unused_perf = '0;
`endif

endmodule

// File: tb/tb_id_dual_issue_ctrl.sv
// Bench for id_dual_issue_ctrl: directed scenarios plus randomized traffic
// compared against an in-order issue reference model.
module tb_id_dual_issue_ctrl;

    localparam int REG_AW     = 5;
    localparam int PERF_CNT_W = 16;

    logic CLK = 1'b0;
    logic RST;
    logic id1_valid, id2_valid, id_order;
    logic [REG_AW-1:0] id1_rs1, id1_rs2, id1_rd, id2_rs1, id2_rs2, id2_rd;
    logic id1_regwrite, id1_memop, id1_branch, id2_regwrite, id2_memop, id2_branch;
    logic ex1_valid, ex1_load, ex2_valid, ex2_load, ex_flush;
    logic [REG_AW-1:0] ex1_rd, ex2_rd;
    logic id1_act, id2_act, ex1_issue, ex2_issue, id_hold, split_q;
`ifdef ID_ISSUE_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall_cnt, perf_split_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic m_split;
    int   m_stall, m_splits;

    id_dual_issue_ctrl #(.REG_AW(REG_AW), .PERF_CNT_W(PERF_CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .id1_valid(id1_valid), .id2_valid(id2_valid), .id_order(id_order),
        .id1_rs1(id1_rs1), .id1_rs2(id1_rs2), .id1_rd(id1_rd),
        .id1_regwrite(id1_regwrite), .id1_memop(id1_memop), .id1_branch(id1_branch),
        .id2_rs1(id2_rs1), .id2_rs2(id2_rs2), .id2_rd(id2_rd),
        .id2_regwrite(id2_regwrite), .id2_memop(id2_memop), .id2_branch(id2_branch),
        .ex1_valid(ex1_valid), .ex1_load(ex1_load), .ex1_rd(ex1_rd),
        .ex2_valid(ex2_valid), .ex2_load(ex2_load), .ex2_rd(ex2_rd),
        .ex_flush(ex_flush),
        .id1_act(id1_act), .id2_act(id2_act),
        .ex1_issue(ex1_issue), .ex2_issue(ex2_issue),
        .id_hold(id_hold), .split_q(split_q)
`ifdef ID_ISSUE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_split_cnt(perf_split_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        id1_valid = 0; id2_valid = 0; id_order = 0;
        id1_rs1 = 0; id1_rs2 = 0; id1_rd = 0; id1_regwrite = 0; id1_memop = 0; id1_branch = 0;
        id2_rs1 = 0; id2_rs2 = 0; id2_rd = 0; id2_regwrite = 0; id2_memop = 0; id2_branch = 0;
        ex1_valid = 0; ex1_load = 0; ex1_rd = 0; ex2_valid = 0; ex2_load = 0; ex2_rd = 0;
        ex_flush = 0;
    endtask

    task automatic setp(input int p, input int r1, input int r2, input int rd,
                        input bit rw, input bit mem, input bit br);
        if (p == 1) begin
            id1_valid = 1; id1_rs1 = REG_AW'(r1); id1_rs2 = REG_AW'(r2); id1_rd = REG_AW'(rd);
            id1_regwrite = rw; id1_memop = mem; id1_branch = br;
        end else begin
            id2_valid = 1; id2_rs1 = REG_AW'(r1); id2_rs2 = REG_AW'(r2); id2_rd = REG_AW'(rd);
            id2_regwrite = rw; id2_memop = mem; id2_branch = br;
        end
    endtask

    // Reference: pick older/younger, then apply in-order issue rules.
    task automatic model(output logic e1, output logic e2, output logic h, output logic ns);
        logic v[2], rw[2], mem[2], br[2], lu[2], exv[2], exl[2], iss[2], pair;
        logic [REG_AW-1:0] s1[2], s2[2], d[2], exd[2];
        int o, y;
        v = '{id1_valid, id2_valid};       rw = '{id1_regwrite, id2_regwrite};
        mem = '{id1_memop, id2_memop};     br = '{id1_branch, id2_branch};
        s1 = '{id1_rs1, id2_rs1}; s2 = '{id1_rs2, id2_rs2}; d = '{id1_rd, id2_rd};
        exv = '{ex1_valid, ex2_valid}; exl = '{ex1_load, ex2_load}; exd = '{ex1_rd, ex2_rd};
        for (int p = 0; p < 2; p++) begin
            lu[p] = 0;
            for (int k = 0; k < 2; k++)
                if (v[p] && exv[k] && exl[k] && exd[k] != 0 && (s1[p] == exd[k] || s2[p] == exd[k]))
                    lu[p] = 1;
        end
        o = (v[0] && v[1]) ? (id_order ? 1 : 0) : (v[1] ? 1 : 0);
        y = 1 - o;
        pair = (rw[o] && d[o] != 0 && (s1[y] == d[o] || s2[y] == d[o])) ||
               (rw[o] && rw[y] && d[o] == d[y] && d[o] != 0) ||
               (mem[0] && mem[1]) || (br[0] && br[1]);
        iss = '{0, 0}; h = 0; ns = m_split;
        if (ex_flush) ns = 0;
        else if (!m_split) begin
            if (!v[o] || lu[o]) h = v[0] | v[1];
            else begin
                iss[o] = 1;
                if (v[y]) begin
                    if (!pair && !lu[y]) iss[y] = 1;
                    else begin h = 1; ns = 1; end
                end
            end
        end else begin
            if (v[0] && v[1] && lu[y]) h = 1;
            else begin iss[y] = v[0] && v[1]; ns = 0; end
        end
        e1 = iss[0]; e2 = iss[1];
    endtask

    // Compare against the model now, then advance the model at the next posedge.
    task automatic tick(input string tag);
        logic e1, e2, h, ns;
        model(e1, e2, h, ns);
        chk({tag, ".m_ex1"}, 32'(ex1_issue), 32'(e1));
        chk({tag, ".m_ex2"}, 32'(ex2_issue), 32'(e2));
        chk({tag, ".m_hold"}, 32'(id_hold), 32'(h));
        chk({tag, ".m_split"}, 32'(split_q), 32'(m_split));
        chk({tag, ".act"}, 32'({id1_act, id2_act}), 32'(2'b11));
`ifdef ID_ISSUE_PERF_EN
        chk({tag, ".m_pstall"}, 32'(perf_stall_cnt), 32'(m_stall));
        chk({tag, ".m_psplit"}, 32'(perf_split_cnt), 32'(m_splits));
`endif
        @(posedge CLK);
        if (h && !ex_flush && m_stall < 65535) m_stall++;
        if (!m_split && ns && m_splits < 65535) m_splits++;
        m_split = ns;
    endtask

    task automatic expect4(input string tag, input bit e1, input bit e2, input bit h, input bit sq);
        chk({tag, ".ex1"}, 32'(ex1_issue), 32'(e1));
        chk({tag, ".ex2"}, 32'(ex2_issue), 32'(e2));
        chk({tag, ".hold"}, 32'(id_hold), 32'(h));
        chk({tag, ".split"}, 32'(split_q), 32'(sq));
    endtask

    task automatic model_reset();
        m_split = 0; m_stall = 0; m_splits = 0;
    endtask

    task automatic raw_pair();
        clr(); setp(1, 1, 2, 5, 1, 0, 0); setp(2, 5, 3, 6, 1, 0, 0);
    endtask

    initial begin
        clr(); model_reset();
        RST = 1;
        setp(1, 1, 2, 5, 1, 0, 0); setp(2, 3, 4, 6, 1, 0, 0);
        #3;
        expect4("rst", 0, 0, 0, 0);
        chk("rst.act", 32'({id1_act, id2_act}), 32'(0));
        @(negedge CLK); RST = 0;

        // Independent pair issues together.
        @(negedge CLK); clr(); setp(1, 1, 2, 5, 1, 0, 0); setp(2, 3, 4, 6, 1, 0, 0);
        #1; expect4("indep", 1, 1, 0, 0); tick("indep");

        // Intra-pair RAW splits across two cycles.
        @(negedge CLK); raw_pair(); #1; expect4("raw0", 1, 0, 1, 0); tick("raw0");
        @(negedge CLK); #1; expect4("raw1", 0, 1, 0, 1); tick("raw1");

        // Load-use on the older (pipe2) instruction.
        @(negedge CLK); clr(); id_order = 1;
        setp(1, 1, 2, 8, 1, 0, 0); setp(2, 7, 0, 9, 1, 0, 0);
        ex2_valid = 1; ex2_load = 1; ex2_rd = 7;
        #1; expect4("lu0", 0, 0, 1, 0); tick("lu0");
        @(negedge CLK); ex2_load = 0; #1; expect4("lu1", 1, 1, 0, 0); tick("lu1");

        // Dual memop, pipe2 older.
        @(negedge CLK); clr(); id_order = 1;
        setp(1, 1, 2, 8, 1, 1, 0); setp(2, 3, 4, 9, 1, 1, 0);
        #1; expect4("mem0", 0, 1, 1, 0); tick("mem0");
        @(negedge CLK); #1; expect4("mem1", 1, 0, 0, 1); tick("mem1");

        // WAW on x0 is not a hazard.
        @(negedge CLK); clr(); setp(1, 1, 2, 0, 1, 0, 0); setp(2, 3, 4, 0, 1, 0, 0);
        #1; expect4("waw0", 1, 1, 0, 0); tick("waw0");

        // Flush while in SPLIT.
        @(negedge CLK); raw_pair(); #1; tick("fl0");
        @(negedge CLK); ex_flush = 1; #1; expect4("fl1", 0, 0, 0, 1); tick("fl1");
        @(negedge CLK); clr(); #1; expect4("fl2", 0, 0, 0, 0); tick("fl2");

        // Asynchronous reset in the middle of SPLIT.
        @(negedge CLK); raw_pair(); #1; tick("rs0");
        @(negedge CLK); #1 RST = 1; #1;
        expect4("rsmid", 0, 0, 0, 0);
        chk("rsmid.act", 32'({id1_act, id2_act}), 32'(0));
`ifdef ID_ISSUE_PERF_EN
        chk("rsmid.pstall", 32'(perf_stall_cnt), 32'(0));
        chk("rsmid.psplit", 32'(perf_split_cnt), 32'(0));
`endif
        #1 RST = 0; model_reset(); #1;
        expect4("rs1", 1, 0, 1, 0); tick("rs1");

`ifdef ID_ISSUE_PERF_EN
        @(negedge CLK); #1 RST = 1; #1 RST = 0; model_reset();
        @(negedge CLK); clr(); id_order = 1;
        setp(1, 1, 2, 8, 1, 0, 0); setp(2, 7, 0, 9, 1, 0, 0);
        ex2_valid = 1; ex2_load = 1; ex2_rd = 7;
        #1; tick("pf0");
        @(negedge CLK); #1; tick("pf1");
        @(negedge CLK); raw_pair(); #1; tick("pf2");
        @(negedge CLK); #1; tick("pf3");
        @(negedge CLK); clr(); #1;
        chk("perf.stall", 32'(perf_stall_cnt), 32'(3));
        chk("perf.split", 32'(perf_split_cnt), 32'(1));
        #1 RST = 1; #1;
        chk("perf.rst_stall", 32'(perf_stall_cnt), 32'(0));
        chk("perf.rst_split", 32'(perf_split_cnt), 32'(0));
        #1 RST = 0; model_reset();
`endif

        // Randomized traffic with small register ids to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            id1_valid = 1'($urandom); id2_valid = 1'($urandom); id_order = 1'($urandom);
            id1_rs1 = REG_AW'($urandom_range(0, 3)); id1_rs2 = REG_AW'($urandom_range(0, 3));
            id1_rd = REG_AW'($urandom_range(0, 3));  id2_rs1 = REG_AW'($urandom_range(0, 3));
            id2_rs2 = REG_AW'($urandom_range(0, 3)); id2_rd = REG_AW'($urandom_range(0, 3));
            id1_regwrite = 1'($urandom); id2_regwrite = 1'($urandom);
            id1_memop = ($urandom_range(0, 3) == 0); id2_memop = ($urandom_range(0, 3) == 0);
            id1_branch = ($urandom_range(0, 3) == 0); id2_branch = ($urandom_range(0, 3) == 0);
            ex1_valid = 1'($urandom); ex1_load = 1'($urandom); ex1_rd = REG_AW'($urandom_range(0, 3));
            ex2_valid = 1'($urandom); ex2_load = 1'($urandom); ex2_rd = REG_AW'($urandom_range(0, 3));
            ex_flush = ($urandom_range(0, 15) == 0);
            #1; tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
